// File: rtl/csa_mul_seq.sv
// csa_mul_seq: sequential unsigned multiplier.
// One multiplier bit is folded into a carry-save (sum, carry) pair per cycle,
// then a single carry-propagate add resolves the product and the selected
// half (low for MUL, high for MULHU) is registered onto P.
//
// Handshake: start is sampled on a rising edge only while the block is not
// busy (IDLE or DONE); A, B and hi_sel are captured on that same edge.
// Exactly size+1 edges later done pulses high for one cycle with P valid.
// P then holds until the next resolve. busy covers ACCUM and RESOLVE.
module csa_mul_seq #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [size-1:0] A,
  input  logic [size-1:0] B,
  input  logic            hi_sel,
  output logic            busy,
  output logic            done,
  output logic [size-1:0] P
);

  localparam int PW = 2 * size;
  localparam int CW = $clog2(size);
  localparam logic [CW-1:0] LAST = CW'(size - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [size-1:0] a_q, a_d;
  logic [size-1:0] b_q, b_d;
  logic            hi_q, hi_d;
  logic [PW-1:0]   sum_q, sum_d;
  logic [PW-1:0]   carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [size-1:0] p_q, p_d;

  logic          accept;
  logic [PW-1:0] pp;
  logic [PW-1:0] carry_sh;
  logic [PW-1:0] csa_sum;
  logic [PW-1:0] csa_cy;
  logic [PW-1:0] product;

  // State and datapath registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // Next-state logic: start is honoured only when not busy.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_ACCUM;
      ST_ACCUM:   if (cnt_q == LAST) state_d = ST_RESOLVE;
      ST_RESOLVE: state_d = ST_DONE;
      ST_DONE:    state_d = start ? ST_ACCUM : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, one 3:2 compression per ACCUM cycle, final add in RESOLVE.
  always_comb begin
    accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    pp       = b_q[cnt_q] ? (PW'(a_q) << cnt_q) : '0;
    carry_sh = carry_q << 1;
    csa_sum  = sum_q ^ carry_sh ^ pp;
    csa_cy   = (sum_q & carry_sh) | (sum_q & pp) | (carry_sh & pp);
    product  = sum_q + carry_sh;

    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    if (accept) begin
      a_d     = A;
      b_d     = B;
      hi_d    = hi_sel;
      sum_d   = '0;
      carry_d = '0;
      cnt_d   = '0;
    end else if (state_q == ST_ACCUM) begin
      sum_d   = csa_sum;
      carry_d = csa_cy;
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end else if (state_q == ST_RESOLVE) begin
      p_d = hi_q ? product[PW-1:size] : product[size-1:0];
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy = (state_q == ST_ACCUM) || (state_q == ST_RESOLVE);
    done = (state_q == ST_DONE);
  end

  assign P = p_q;

endmodule
